// File: rtl/ppg_channel_scheduler.sv
// PPG front-end scheduler: sequences IR/RED/ambient phases, settles, averages ADC
// samples per phase and emits tagged samples; calibration applies at frame boundaries.
module ppg_channel_scheduler #(
  parameter int SETTLE_CYC = 16,
  parameter int AVG_LOG2   = 2,
  parameter int AMBIENT_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       cal_load,
  input  logic [6:0] dc_ir,
  input  logic [6:0] dc_red,
  input  logic [3:0] pga_ir,
  input  logic [3:0] pga_red,
  input  logic [7:0] ADC,
  output logic [6:0] DC_Comp,
  output logic [3:0] PGA_Gain,
  output logic       LED_IR,
  output logic       LED_RED,
  output logic [7:0] sample_out,
  output logic [1:0] sample_ch,
  output logic       sample_sat,
  output logic       sample_valid,
  output logic       frame_done,
  output logic       busy
);

  localparam int         ACC_W       = 8 + AVG_LOG2;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] ACQ_LAST    = 8'((1 << AVG_LOG2) - 1);
  localparam logic [6:0] DC_RESET    = 7'd64;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SETTLE, S_ACQUIRE, S_EMIT} state_t;
  typedef enum logic [1:0] {PH_AMB = 2'd0, PH_IR = 2'd1, PH_RED = 2'd2} phase_t;

  state_t             state_q, state_d;
  phase_t             phase_q, phase_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               sat_q, sat_d;

  logic [6:0] act_dc_ir_q, act_dc_ir_d, act_dc_red_q, act_dc_red_d;
  logic [3:0] act_pga_ir_q, act_pga_ir_d, act_pga_red_q, act_pga_red_d;
  logic [6:0] pend_dc_ir_q, pend_dc_ir_d, pend_dc_red_q, pend_dc_red_d;
  logic [3:0] pend_pga_ir_q, pend_pga_ir_d, pend_pga_red_q, pend_pga_red_d;
  logic       pend_flag_q, pend_flag_d;

  logic [6:0] dc_q, dc_d;
  logic [3:0] pga_q, pga_d;
  logic       led_ir_q, led_ir_d, led_red_q, led_red_d;
  logic [7:0] sample_out_q, sample_out_d;
  logic [1:0] sample_ch_q, sample_ch_d;
  logic       sample_sat_q, sample_sat_d;
  logic       sample_valid_q, sample_valid_d;
  logic       frame_done_q, frame_done_d;
  logic       busy_q, busy_d;

  logic [ACC_W-1:0] sum;
  logic             adc_sat;
  logic             last_phase;
  logic             start_frame;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d        = state_q;
    phase_d        = phase_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    sat_d          = sat_q;
    act_dc_ir_d    = act_dc_ir_q;
    act_dc_red_d   = act_dc_red_q;
    act_pga_ir_d   = act_pga_ir_q;
    act_pga_red_d  = act_pga_red_q;
    pend_dc_ir_d   = pend_dc_ir_q;
    pend_dc_red_d  = pend_dc_red_q;
    pend_pga_ir_d  = pend_pga_ir_q;
    pend_pga_red_d = pend_pga_red_q;
    pend_flag_d    = pend_flag_q;
    dc_d           = dc_q;
    pga_d          = pga_q;
    led_ir_d       = led_ir_q;
    led_red_d      = led_red_q;
    sample_out_d   = sample_out_q;
    sample_ch_d    = sample_ch_q;
    sample_sat_d   = sample_sat_q;
    sample_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    start_frame    = 1'b0;

    sum        = acc_q + ACC_W'(ADC);
    adc_sat    = (ADC == 8'd0) || (ADC == 8'hFF);
    last_phase = (phase_q == PH_AMB) || ((phase_q == PH_RED) && (AMBIENT_EN == 0));

    unique case (state_q)
      S_IDLE: begin
        if (enable) start_frame = 1'b1;
      end
      S_SETUP: begin
        state_d = S_SETTLE;
        cnt_d   = 8'd0;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_ACQUIRE;
          cnt_d   = 8'd0;
          acc_d   = '0;
          sat_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ACQUIRE: begin
        acc_d = sum;
        sat_d = sat_q | adc_sat;
        if (cnt_q == ACQ_LAST) begin
          // The last sample lands on the same edge the average is registered.
          state_d        = S_EMIT;
          sample_out_d   = 8'(sum >> AVG_LOG2);
          sample_ch_d    = phase_q;
          sample_sat_d   = sat_q | adc_sat;
          sample_valid_d = 1'b1;
          frame_done_d   = last_phase;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_EMIT: begin
        if (last_phase) begin
          if (enable) begin
            start_frame = 1'b1;
          end else begin
            state_d   = S_IDLE;
            led_ir_d  = 1'b0;
            led_red_d = 1'b0;
            dc_d      = 7'd0;
          end
        end else begin
          state_d = S_SETUP;
          phase_d = (phase_q == PH_IR) ? PH_RED : PH_AMB;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_frame) begin
      state_d = S_SETUP;
      phase_d = PH_IR;
      if (pend_flag_q) begin
        act_dc_ir_d   = pend_dc_ir_q;
        act_dc_red_d  = pend_dc_red_q;
        act_pga_ir_d  = pend_pga_ir_q;
        act_pga_red_d = pend_pga_red_q;
        pend_flag_d   = 1'b0;
      end
    end

    // Front-end drives only move on the edge entering SETUP.
    if (state_d == S_SETUP) begin
      unique case (phase_d)
        PH_IR: begin
          led_ir_d  = 1'b1;
          led_red_d = 1'b0;
          dc_d      = act_dc_ir_d;
          pga_d     = act_pga_ir_d;
        end
        PH_RED: begin
          led_ir_d  = 1'b0;
          led_red_d = 1'b1;
          dc_d      = act_dc_red_d;
          pga_d     = act_pga_red_d;
        end
        default: begin
          led_ir_d  = 1'b0;
          led_red_d = 1'b0;
          dc_d      = 7'd0;
          pga_d     = act_pga_ir_d;
        end
      endcase
    end

    // A load coinciding with a frame start is kept for the following frame.
    if (cal_load) begin
      pend_dc_ir_d   = dc_ir;
      pend_dc_red_d  = dc_red;
      pend_pga_ir_d  = pga_ir;
      pend_pga_red_d = pga_red;
      pend_flag_d    = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      phase_q        <= PH_AMB;
      cnt_q          <= 8'd0;
      acc_q          <= '0;
      sat_q          <= 1'b0;
      act_dc_ir_q    <= DC_RESET;
      act_dc_red_q   <= DC_RESET;
      act_pga_ir_q   <= 4'd0;
      act_pga_red_q  <= 4'd0;
      pend_dc_ir_q   <= DC_RESET;
      pend_dc_red_q  <= DC_RESET;
      pend_pga_ir_q  <= 4'd0;
      pend_pga_red_q <= 4'd0;
      pend_flag_q    <= 1'b0;
      dc_q           <= 7'd0;
      pga_q          <= 4'd0;
      led_ir_q       <= 1'b0;
      led_red_q      <= 1'b0;
      sample_out_q   <= 8'd0;
      sample_ch_q    <= 2'd0;
      sample_sat_q   <= 1'b0;
      sample_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      sat_q          <= sat_d;
      act_dc_ir_q    <= act_dc_ir_d;
      act_dc_red_q   <= act_dc_red_d;
      act_pga_ir_q   <= act_pga_ir_d;
      act_pga_red_q  <= act_pga_red_d;
      pend_dc_ir_q   <= pend_dc_ir_d;
      pend_dc_red_q  <= pend_dc_red_d;
      pend_pga_ir_q  <= pend_pga_ir_d;
      pend_pga_red_q <= pend_pga_red_d;
      pend_flag_q    <= pend_flag_d;
      dc_q           <= dc_d;
      pga_q          <= pga_d;
      led_ir_q       <= led_ir_d;
      led_red_q      <= led_red_d;
      sample_out_q   <= sample_out_d;
      sample_ch_q    <= sample_ch_d;
      sample_sat_q   <= sample_sat_d;
      sample_valid_q <= sample_valid_d;
      frame_done_q   <= frame_done_d;
      busy_q         <= busy_d;
    end
  end

  assign DC_Comp      = dc_q;
  assign PGA_Gain     = pga_q;
  assign LED_IR       = led_ir_q;
  assign LED_RED      = led_red_q;
  assign sample_out   = sample_out_q;
  assign sample_ch    = sample_ch_q;
  assign sample_sat   = sample_sat_q;
  assign sample_valid = sample_valid_q;
  assign frame_done   = frame_done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ppg_channel_scheduler.sv
// Bench for ppg_channel_scheduler: a frame-timeline model checks two instances
// (ambient on / off) every cycle, plus directed literal checks.
module tb_ppg_channel_scheduler;

  localparam int SETTLE = 16;
  localparam int L      = 2;
  localparam int N      = 1 << L;
  localparam int P      = SETTLE + N + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       cal_load = 1'b0;
  logic [6:0] dc_ir = 7'd64, dc_red = 7'd64;
  logic [3:0] pga_ir = 4'd0, pga_red = 4'd0;
  logic [7:0] adc = 8'd100;

  logic [6:0] a_dc, b_dc;
  logic [3:0] a_pga, b_pga;
  logic       a_lir, a_lred, b_lir, b_lred;
  logic [7:0] a_sout, b_sout;
  logic [1:0] a_sch, b_sch;
  logic       a_ssat, a_sv, a_fd, a_busy, b_ssat, b_sv, b_fd, b_busy;

  ppg_channel_scheduler #(.SETTLE_CYC(SETTLE), .AVG_LOG2(L), .AMBIENT_EN(1)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .cal_load(cal_load),
    .dc_ir(dc_ir), .dc_red(dc_red), .pga_ir(pga_ir), .pga_red(pga_red), .ADC(adc),
    .DC_Comp(a_dc), .PGA_Gain(a_pga), .LED_IR(a_lir), .LED_RED(a_lred),
    .sample_out(a_sout), .sample_ch(a_sch), .sample_sat(a_ssat),
    .sample_valid(a_sv), .frame_done(a_fd), .busy(a_busy)
  );

  ppg_channel_scheduler #(.SETTLE_CYC(SETTLE), .AVG_LOG2(L), .AMBIENT_EN(0)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .cal_load(cal_load),
    .dc_ir(dc_ir), .dc_red(dc_red), .pga_ir(pga_ir), .pga_red(pga_red), .ADC(adc),
    .DC_Comp(b_dc), .PGA_Gain(b_pga), .LED_IR(b_lir), .LED_RED(b_lred),
    .sample_out(b_sout), .sample_ch(b_sch), .sample_sat(b_ssat),
    .sample_valid(b_sv), .frame_done(b_fd), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position in the frame timeline (t counts cycles since SETUP(IR)).
  bit m_run[2], m_sat[2], m_pflag[2];
  int m_t[2], m_sum[2];
  int m_adir[2], m_adred[2], m_apir[2], m_apred[2];
  int m_pdir[2], m_pdred[2], m_ppir[2], m_ppred[2];
  int e_dc[2], e_pga[2], e_lir[2], e_lred[2], e_sout[2], e_sch[2], e_ssat[2];
  int e_sv[2], e_fd[2], e_busy[2];

  function automatic int ph_code(input int idx);
    return (idx == 0) ? 1 : (idx == 1) ? 2 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_sat[k] = 0; m_pflag[k] = 0; m_t[k] = 0; m_sum[k] = 0;
      m_adir[k] = 64; m_adred[k] = 64; m_apir[k] = 0; m_apred[k] = 0;
      m_pdir[k] = 64; m_pdred[k] = 64; m_ppir[k] = 0; m_ppred[k] = 0;
      e_dc[k] = 0; e_pga[k] = 0; e_lir[k] = 0; e_lred[k] = 0; e_sout[k] = 0;
      e_sch[k] = 0; e_ssat[k] = 0; e_sv[k] = 0; e_fd[k] = 0; e_busy[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int  nph;
      int  o;
      int  idx;
      int  code;
      bit  start;
      nph   = (k == 0) ? 3 : 2;
      start = 0;
      e_sv[k] = 0;
      e_fd[k] = 0;
      if (!m_run[k]) begin
        start = enable;
      end else begin
        o   = m_t[k] % P;
        idx = m_t[k] / P;
        if (o >= SETTLE + 1 && o <= SETTLE + N) begin
          m_sum[k] += int'(adc);
          if (adc == 8'd0 || adc == 8'd255) m_sat[k] = 1;
        end
        if (o == SETTLE + N) begin
          e_sout[k] = m_sum[k] >> L;
          e_sch[k]  = ph_code(idx);
          e_ssat[k] = m_sat[k];
          e_sv[k]   = 1;
          e_fd[k]   = (idx == nph - 1);
          m_sum[k]  = 0;
          m_sat[k]  = 0;
        end
        if (o == P - 1 && idx == nph - 1) begin
          if (enable) start = 1;
          else m_run[k] = 0;
        end else begin
          m_t[k]++;
        end
      end
      if (start) begin
        if (m_pflag[k]) begin
          m_adir[k] = m_pdir[k]; m_adred[k] = m_pdred[k];
          m_apir[k] = m_ppir[k]; m_apred[k] = m_ppred[k];
          m_pflag[k] = 0;
        end
        m_run[k] = 1;
        m_t[k]   = 0;
      end
      if (cal_load) begin
        m_pdir[k] = dc_ir; m_pdred[k] = dc_red; m_ppir[k] = pga_ir; m_ppred[k] = pga_red;
        m_pflag[k] = 1;
      end
      if (m_run[k]) begin
        code = ph_code(m_t[k] / P);
        e_lir[k]  = (code == 1);
        e_lred[k] = (code == 2);
        e_dc[k]   = (code == 1) ? m_adir[k] : (code == 2) ? m_adred[k] : 0;
        e_pga[k]  = (code == 2) ? m_apred[k] : m_apir[k];
        e_busy[k] = 1;
      end else begin
        e_lir[k] = 0; e_lred[k] = 0; e_dc[k] = 0; e_busy[k] = 0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  task automatic cmp_inst(input int k, input string nm, input logic [6:0] dc,
                          input logic [3:0] pga, input logic lir, input logic lred,
                          input logic [7:0] sout, input logic [1:0] sch, input logic ssat,
                          input logic sv, input logic fd, input logic bsy);
    check({nm, ".DC_Comp"},      int'(dc),   e_dc[k]);
    check({nm, ".PGA_Gain"},     int'(pga),  e_pga[k]);
    check({nm, ".LED_IR"},       int'(lir),  e_lir[k]);
    check({nm, ".LED_RED"},      int'(lred), e_lred[k]);
    check({nm, ".sample_out"},   int'(sout), e_sout[k]);
    check({nm, ".sample_ch"},    int'(sch),  e_sch[k]);
    check({nm, ".sample_sat"},   int'(ssat), e_ssat[k]);
    check({nm, ".sample_valid"}, int'(sv),   e_sv[k]);
    check({nm, ".frame_done"},   int'(fd),   e_fd[k]);
    check({nm, ".busy"},         int'(bsy),  e_busy[k]);
  endtask

  always @(negedge clk) begin
    cmp_inst(0, "A", a_dc, a_pga, a_lir, a_lred, a_sout, a_sch, a_ssat, a_sv, a_fd, a_busy);
    cmp_inst(1, "B", b_dc, b_pga, b_lir, b_lred, b_sout, b_sch, b_ssat, b_sv, b_fd, b_busy);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int inst, output int cycles);
    bit seen;
    seen   = 0;
    cycles = 0;
    while (!seen && cycles < 300) begin
      tick(1);
      cycles++;
      seen = (inst == 0) ? a_sv : b_sv;
    end
    check("strobe seen before timeout", int'(seen), 1);
  endtask

  task automatic wait_ch(input int ch);
    bit seen;
    int cycles;
    seen   = 0;
    cycles = 0;
    while (!seen && cycles < 300) begin
      tick(1);
      cycles++;
      seen = a_sv && (int'(a_sch) == ch);
    end
    check("channel strobe seen before timeout", int'(seen), 1);
  endtask

  initial begin
    int c;
    tick(3);
    check("reset DC_Comp", int'(a_dc), 0);
    check("reset busy", int'(a_busy), 0);
    rst = 1'b0;
    tick(2);
    check("idle busy", int'(a_busy), 0);

    // Constant ADC: one full frame, 22 cycles per phase.
    enable = 1'b1;
    wait_valid(0, c);
    check("IR latency", c, 22);
    check("IR out", int'(a_sout), 100);
    check("IR ch", int'(a_sch), 1);
    check("IR LED_IR", int'(a_lir), 1);
    check("IR frame_done", int'(a_fd), 0);
    check("IR DC_Comp default", int'(a_dc), 64);
    wait_valid(0, c);
    check("RED period", c, 22);
    check("RED ch", int'(a_sch), 2);
    check("RED LED_IR", int'(a_lir), 0);
    check("RED LED_RED", int'(a_lred), 1);
    wait_valid(0, c);
    check("AMB period", c, 22);
    check("AMB ch", int'(a_sch), 0);
    check("AMB frame_done", int'(a_fd), 1);

    // Calibration load in the RED phase of frame 2 applies from frame 3.
    tick(30);
    dc_ir = 7'd90; pga_ir = 4'd5; cal_load = 1'b1;
    tick(1);
    cal_load = 1'b0;
    check("RED DC unchanged after load", int'(a_dc), 64);
    wait_ch(0);
    tick(1);
    check("new IR DC_Comp", int'(a_dc), 90);
    check("new IR PGA_Gain", int'(a_pga), 5);

    // Averaging 10,11,12,14 -> 47>>2 = 11.
    tick(17);
    adc = 8'd10; tick(1);
    adc = 8'd11; tick(1);
    adc = 8'd12; tick(1);
    adc = 8'd14; tick(1);
    adc = 8'd100;
    check("avg valid", int'(a_sv), 1);
    check("avg out", int'(a_sout), 11);
    check("avg sat", int'(a_ssat), 0);
    tick(23);
    check("AMB DC_Comp", int'(a_dc), 0);
    check("AMB PGA_Gain", int'(a_pga), 5);
    wait_ch(0);

    // 10,255,12,14 -> 291>>2 = 72, saturation flagged.
    tick(18);
    adc = 8'd10;  tick(1);
    adc = 8'd255; tick(1);
    adc = 8'd12;  tick(1);
    adc = 8'd14;  tick(1);
    adc = 8'd100;
    check("sat valid", int'(a_sv), 1);
    check("sat out", int'(a_sout), 72);
    check("sat flag", int'(a_ssat), 1);

    // enable dropped inside IR phase: frame still completes.
    wait_ch(0);
    tick(5);
    enable = 1'b0;
    wait_ch(2);
    check("drop RED frame_done", int'(a_fd), 0);
    wait_ch(0);
    check("drop AMB frame_done", int'(a_fd), 1);
    tick(1);
    check("drop idle busy", int'(a_busy), 0);
    check("drop idle LED_IR", int'(a_lir), 0);
    check("drop idle LED_RED", int'(a_lred), 0);
    tick(5);
    check("drop stays idle", int'(a_busy), 0);
    check("B idle", int'(b_busy), 0);

    // Two-phase frame on instance B.
    enable = 1'b1;
    wait_valid(1, c);
    check("B IR latency", c, 22);
    check("B IR ch", int'(b_sch), 1);
    check("B IR frame_done", int'(b_fd), 0);
    wait_valid(1, c);
    check("B RED period", c, 22);
    check("B RED ch", int'(b_sch), 2);
    check("B RED frame_done", int'(b_fd), 1);
    wait_valid(1, c);
    check("B IR again period", c, 22);
    check("B IR again ch", int'(b_sch), 1);

    // Asynchronous reset in IR ACQUIRE of instance A.
    tick(19);
    #2 rst = 1'b1;
    #1;
    check("async rst DC_Comp", int'(a_dc), 0);
    check("async rst LED_IR", int'(a_lir), 0);
    check("async rst busy", int'(a_busy), 0);
    check("async rst sample_out", int'(a_sout), 0);
    check("async rst sample_valid", int'(a_sv), 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    check("restart DC_Comp", int'(a_dc), 64);
    check("restart PGA_Gain", int'(a_pga), 0);
    check("restart LED_IR", int'(a_lir), 1);
    wait_valid(0, c);
    check("restart IR latency", c, 21);
    check("restart IR out", int'(a_sout), 100);
    check("restart IR ch", int'(a_sch), 1);

    enable = 1'b0;
    tick(150);
    check("final A idle", int'(a_busy), 0);
    check("final B idle", int'(b_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ppg_channel_scheduler.md
Name: ppg_channel_scheduler

Overview:
Time-multiplexes the shared optical front-end between IR, RED and ambient (dark) phases: LED drives, DC-compensation DAC, PGA gain and the ADC. For each phase it applies that channel's DC_Comp/PGA settings, waits a settling interval and averages 2^AVG_LOG2 ADC samples. It then emits one tagged sample per phase. Calibration values from the DC/PGA search controller are loaded through a shadow register and take effect only at frame boundaries.

Parameters:
SETTLE_CYC, 16, settle cycles after each phase switch before sampling (legal range 1..255)
AVG_LOG2, 2, log2 of ADC samples averaged per phase (0..4)
AMBIENT_EN, 1, 1 = frame is IR,RED,AMB; 0 = frame is IR,RED

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  run frames while high
cal_load  in  1  one-cycle pulse, capture dc_ir/dc_red/pga_ir/pga_red into pending shadow
dc_ir  in  7  IR DC compensation code
dc_red  in  7  RED DC compensation code
pga_ir  in  4  IR PGA gain code
pga_red  in  4  RED PGA gain code
ADC  in  8  ADC conversion, valid every cycle
DC_Comp  out  7  DC compensation DAC drive
PGA_Gain  out  4  PGA gain drive
LED_IR  out  1  IR LED enable
LED_RED  out  1  RED LED enable
sample_out  out  8  averaged sample
sample_ch  out  2  0=AMB, 1=IR, 2=RED
sample_sat  out  1  a sample in this average was 0 or 255
sample_valid  out  1  one-cycle strobe qualifying sample_*
frame_done  out  1  one-cycle strobe with last sample of frame
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst=1):
  - All outputs 0.
  - State IDLE; counters and accumulator 0; pending flag 0.
  - Active and pending shadows: dc_* = 64, pga_* = 0.
- Outputs: all registered. DC_Comp, PGA_Gain and the LEDs change only on the edge entering SETUP and hold through SETTLE, ACQUIRE and EMIT.
- States: IDLE, SETUP, SETTLE, ACQUIRE, EMIT.
- IDLE: LEDs 0, DC_Comp 0. If enable=1 → SETUP(IR).
- SETUP: exactly 1 cycle; then → SETTLE.
  - IR: LED_IR=1, LED_RED=0, DC_Comp=act_dc_ir, PGA_Gain=act_pga_ir.
  - RED: LED_IR=0, LED_RED=1, DC_Comp=act_dc_red, PGA_Gain=act_pga_red.
  - AMB: both LEDs 0, DC_Comp=0, PGA_Gain=act_pga_ir.
- SETTLE: SETTLE_CYC cycles (counter), then → ACQUIRE with accumulator and sat cleared.
- ACQUIRE: N = 2^AVG_LOG2 cycles.
  - Each cycle adds ADC to an (8+AVG_LOG2)-bit accumulator, so there is no overflow.
  - Sat flag ORs in (ADC==0 || ADC==255).
  - After N samples → EMIT.
- EMIT: 1 cycle.
  - sample_out = acc >> AVG_LOG2 (truncating); sample_ch = phase; sample_sat = sat flag; sample_valid = 1.
  - sample_out/ch/sat hold until the next EMIT.
  - Next phase order: IR→RED; RED→AMB if AMBIENT_EN, else frame end; AMB→frame end.
  - At frame end, frame_done=1 in the same cycle. Then: enable=1 → SETUP(IR); enable=0 → IDLE.
- Phase period = SETTLE_CYC + N + 2 cycles (22 at defaults). Frame = 66 cycles (44 with AMBIENT_EN=0).
- enable deasserted mid-frame: the current frame completes; enable is sampled only at frame end and in IDLE.
- Calibration shadow:
  - cal_load captures the inputs into pending and sets the pending flag. Repeated loads overwrite pending (last wins).
  - On the edge entering SETUP(IR) from EMIT or IDLE: if pending flag was set before that edge, active ← pending and the flag clears.
  - A cal_load on that same edge is captured into pending and applies at the following frame.
  - Settings never change mid-frame.
- Reset mid-operation: immediate return to reset state, sample_valid dropped, no partial sample emitted.

Test Plan:
1. Reset, enable=1, ADC=100 constant → first sample_valid at cycle 22 after leaving IDLE, ch=1, out=100; RED at +22, AMB at +22 with frame_done=1 on the AMB strobe; LED_IR=1 only during IR phase.
2. cal_load with dc_ir=90, pga_ir=5 mid-RED phase → current frame keeps DC_Comp=64 in IR; next IR SETUP drives DC_Comp=90, PGA_Gain=5; AMB phase drives DC_Comp=0, PGA_Gain=5.
3. ACQUIRE samples 10,11,12,14 → sample_out=11 (47>>2), sample_sat=0; repeat with one sample 255 → sample_sat=1.
4. enable dropped during IR phase → RED and AMB still emitted, frame_done pulses, then IDLE with all LEDs 0 and busy=0.
5. AMBIENT_EN=0 → samples alternate ch 1,2 every 22 cycles, frame_done on every RED strobe.
6. rst pulsed during ACQUIRE → outputs 0 asynchronously, no sample_valid; after release with enable=1, a full frame restarts from IR using dc=64.
